chroma_quadrant_split: RTL and testbench

//  Sits between the chroma IDCT/level-shift output and supersample_4x4 on the 4:2:0 path.
//  - Buffers one 8x8 Cb or Cr block.
//  - Emits it as four 4x4 quadrants, one per luma 8x8 block of the MCU.
//  - Order: TL, TR, BL, BR.
//  - Each quadrant feeds the upsampler with a valid/ready handshake.

---
 rtl/chroma_quadrant_split.sv | 151 +++++++++++++++
 tb/tb_chroma_quadrant_split.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_quadrant_split.sv
// Buffers one 8x8 Cb/Cr block and replays it as four 4x4 quadrants (TL, TR, BL, BR).
// Build option SPLIT_DOUBLE_BUF_EN: 2-entry ping-pong buffer with no IDLE bubble.

`ifndef CH
`define CH 2
`endif

module chroma_quadrant_split #(
  parameter int unsigned DW = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(`CH+1)-1:0] in_ch,
  input  logic [7:0][7:0][DW-1:0]  in_block,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(`CH+1)-1:0] out_ch,
  output logic [1:0]               out_quad,
  output logic                     out_last,
  output logic [3:0][3:0][DW-1:0]  out_block,
  output logic                     drop_err
);
  localparam int unsigned NQ  = 4;
  localparam int unsigned ChW = $clog2(`CH+1);

  logic                    accept;
  logic                    keep;
  logic                    hs;
  logic [1:0]              quad_q, quad_d;
  logic                    drop_q;
  logic [ChW-1:0]          cur_ch;
  logic [7:0][7:0][DW-1:0] cur_buf;

  assign accept = in_valid && in_ready;
  assign keep   = (in_ch == ChW'(1)) || (in_ch == ChW'(2));
  assign hs     = out_valid && out_ready;

`ifndef SPLIT_DOUBLE_BUF_EN
  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e                  state_q, state_d;
  logic [7:0][7:0][DW-1:0] buf_q;
  logic [ChW-1:0]          ch_q;

  // Storage is don't-care at reset; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (accept && keep) begin
      buf_q <= in_block;
      ch_q  <= in_ch;
    end
  end

  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    unique case (state_q)
      StIdle: begin
        if (accept && keep) begin
          state_d = StEmit;
          quad_d  = '0;
        end
      end
      StEmit: begin
        if (out_ready) begin
          quad_d = quad_q + 2'd1;
          if (out_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StEmit);
  assign cur_buf   = buf_q;
  assign cur_ch    = ch_q;
`else
  logic [7:0][7:0][DW-1:0] buf_q [2];
  logic [ChW-1:0]          ch_q  [2];
  logic                    wr_q, rd_q;
  logic [1:0]              cnt_q;
  logic                    push, pop;

  assign push = accept && keep;
  assign pop  = hs && out_last;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_q] <= in_block;
      ch_q[wr_q]  <= in_ch;
    end
  end

  // quad wraps 3 -> 0 on the final pop, so the next entry starts at TL.
  always_comb begin
    quad_d = quad_q;
    if (hs) quad_d = quad_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_q ^ push;
      rd_q  <= rd_q ^ pop;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign cur_buf   = buf_q[rd_q];
  assign cur_ch    = ch_q[rd_q];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quad_q <= '0;
      drop_q <= 1'b0;
    end else begin
      quad_q <= quad_d;
      drop_q <= accept && !keep;
    end
  end

  assign out_quad = quad_q;
  assign out_last = out_valid && (quad_q == 2'(NQ - 1));
  assign out_ch   = out_valid ? cur_ch : '0;
  assign drop_err = drop_q;

  always_comb begin
    out_block = '0;
    if (out_valid) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          out_block[r][c] = cur_buf[{quad_q[1], 2'(r)}][{quad_q[0], 2'(c)}];
        end
      end
    end
  end

endmodule

// File: tb/tb_chroma_quadrant_split.sv
// Directed, table-driven bench for chroma_quadrant_split (single- or double-buffer build).
module tb_chroma_quadrant_split;
`ifdef SPLIT_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  typedef logic [7:0][7:0][8:0] blk_t;
  typedef logic [3:0][3:0][8:0] qblk_t;

  typedef struct {
    logic [1:0] ch;
    int         mode;
    bit         drop;
    logic [8:0] spot [4];
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_ch;
  blk_t       in_block;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;
  logic [1:0] out_quad;
  logic       out_last;
  qblk_t      out_block;
  logic       drop_err;

  int total = 0;
  int bad   = 0;

  chroma_quadrant_split #(.DW(9)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_block (in_block),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_quad (out_quad),
    .out_last (out_last),
    .out_block(out_block),
    .drop_err (drop_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic blk_t mk(input int mode);
    blk_t b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        case (mode)
          0:       b[r][c] = 9'(8 * r + c);
          1:       b[r][c] = 9'h100;
          default: b[r][c] = 9'(-1 - (8 * r + c));
        endcase
      end
    end
    return b;
  endfunction

  function automatic qblk_t quad_of(input blk_t b, input int q);
    qblk_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[r][c] = b[r + 4 * (q / 2)][c + 4 * (q % 2)];
      end
    end
    return o;
  endfunction

  task automatic send(input logic [1:0] ch, input blk_t b);
    @(negedge clk);
    chk("send_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_ch    = ch;
    in_block = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_block = '0;
  endtask

  task automatic check_quad(input int q, input logic [1:0] ch, input blk_t b, input bit rdy);
    chk("q_valid", out_valid, 1);
    chk("q_quad", out_quad, q);
    chk("q_last", out_last, (q == 3));
    chk("q_ch", out_ch, ch);
    chk("q_block", out_block, quad_of(b, q));
    chk("q_in_ready", in_ready, rdy);
  endtask

  vec_t vecs [6];
  blk_t blk;
  blk_t blk2;
  qblk_t held;

  initial begin
    vecs[0] = '{2'd1, 0, 1'b0, '{9'd0, 9'd4, 9'd32, 9'd63}};
    vecs[1] = '{2'd2, 1, 1'b0, '{9'h100, 9'h100, 9'h100, 9'h100}};
    vecs[2] = '{2'd0, 0, 1'b1, '{9'd0, 9'd0, 9'd0, 9'd0}};
    vecs[3] = '{2'd2, 2, 1'b0, '{9'h1ff, 9'h1fb, 9'h1df, 9'h1c0}};
    vecs[4] = '{2'd3, 1, 1'b1, '{9'd0, 9'd0, 9'd0, 9'd0}};
    vecs[5] = '{2'd1, 1, 1'b0, '{9'h100, 9'h100, 9'h100, 9'h100}};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_ch     = 2'd0;
    in_block  = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_quad", out_quad, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_drop_err", drop_err, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_in_ready", in_ready, 1);

    // Table: quadrant order, mapping, spot values, drops.
    for (int i = 0; i < 6; i++) begin
      blk = mk(vecs[i].mode);
      send(vecs[i].ch, blk);
      if (vecs[i].drop) begin
        chk("drop_pulse", drop_err, 1);
        chk("drop_no_valid", out_valid, 0);
        chk("drop_in_ready", in_ready, 1);
        @(negedge clk);
        chk("drop_clear", drop_err, 0);
        chk("drop_no_valid2", out_valid, 0);
      end else begin
        for (int q = 0; q < 4; q++) begin
          check_quad(q, vecs[i].ch, blk, DBL);
          chk("spot", out_block[(q == 3) ? 3 : 0][(q == 3) ? 3 : 0], vecs[i].spot[q]);
          chk("no_drop", drop_err, 0);
          @(negedge clk);
        end
        chk("idle_after", out_valid, 0);
      end
    end

    // Backpressure during quadrant 1.
    blk = mk(0);
    send(2'd1, blk);
    check_quad(0, 2'd1, blk, DBL);
    @(negedge clk);
    check_quad(1, 2'd1, blk, DBL);
    held = out_block;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_quad", out_quad, 1);
      chk("bp_valid", out_valid, 1);
      chk("bp_block", out_block, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_quad(2, 2'd1, blk, DBL);
    @(negedge clk);
    check_quad(3, 2'd1, blk, DBL);
    @(negedge clk);
    chk("bp_idle", out_valid, 0);

    // Async reset in the middle of quadrant 2.
    blk = mk(2);
    send(2'd1, blk);
    repeat (2) @(negedge clk);
    chk("rst_mid_quad", out_quad, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_quad", out_quad, 0);
    chk("rst_async_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_valid", out_valid, 0);
    blk = mk(0);
    send(2'd1, blk);
    for (int q = 0; q < 4; q++) begin
      check_quad(q, 2'd1, blk, DBL);
      @(negedge clk);
    end
    chk("rst_post_idle", out_valid, 0);

`ifdef SPLIT_DOUBLE_BUF_EN
    // Back-to-back Cb then Cr: 8 consecutive quadrants, no bubble.
    blk  = mk(0);
    blk2 = mk(2);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd1;
    in_block = blk;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check_quad(i % 4, (i < 4) ? 2'd1 : 2'd2, (i < 4) ? blk : blk2,
                 (i == 1 || i == 2 || i == 3) ? 1'b0 : 1'b1);
      if (i == 0) begin
        in_ch    = 2'd2;
        in_block = blk2;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("dbl_idle", out_valid, 0);
    chk("dbl_ready", in_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
